// File: rtl/tnn_feature_loader_pkg.sv
// Shared definitions for the pendigits feature loader: FSM states,
// dataset constants and derived vector widths.
package tnn_feature_loader_pkg;

    localparam int PD_FEAT_CNT  = 16;
    localparam int PD_FEAT_BITS = 4;
    localparam int PD_CLASS_CNT = 10;

    localparam int PRED_W     = $clog2(PD_CLASS_CNT);
    localparam int FEAT_VEC_W = PD_FEAT_CNT * PD_FEAT_BITS;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } tnn_state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tnn_feature_loader.sv
// Serial feature packer and run controller for the sequential ternary
// classifier; one inference in flight, result handed off over valid/ready.
module tnn_feature_loader
    import tnn_feature_loader_pkg::*;
#(
    parameter int FEAT_CNT    = PD_FEAT_CNT,
    parameter int FEAT_BITS   = PD_FEAT_BITS,
    parameter int CLASS_CNT   = PD_CLASS_CNT,
    parameter int TNN_LATENCY = 64,
    localparam int PW         = $clog2(CLASS_CNT),
    localparam int VW         = FEAT_CNT * FEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FEAT_BITS-1:0] in_feat,
    output logic [VW-1:0]        features,
    output logic                 tnn_rst,
    input  logic [PW-1:0]        tnn_pred,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PW-1:0]        out_pred,
    output logic                 busy,
    output tnn_state_e           dbg_state
);

    // Handshakes: a beat or result moves on a clock edge where valid and
    // ready are both high; valid is never withdrawn before that edge.

    localparam int BEAT_W = cnt_width(FEAT_CNT);
    localparam int CYC_W  = $clog2(TNN_LATENCY + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FEAT_CNT - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TNN_LATENCY - 1);

    tnn_state_e          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [VW-1:0]       features_q, features_d;
    logic                out_valid_q, out_valid_d;
    logic [PW-1:0]       out_pred_q, out_pred_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            beat_q      <= '0;
            cyc_q       <= '0;
            features_q  <= '0;
            out_valid_q <= 1'b0;
            out_pred_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            features_q  <= features_d;
            out_valid_q <= out_valid_d;
            out_pred_q  <= out_pred_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        features_d  = features_q;
        out_valid_d = out_valid_q;
        out_pred_d  = out_pred_q;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    features_d[int'(beat_q)*FEAT_BITS +: FEAT_BITS] = in_feat;
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = START;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            START: begin
                cyc_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Counter value equals cycles elapsed since restart release.
                if (cyc_q == CYC_LAST) begin
                    cyc_d       = '0;
                    out_pred_d  = tnn_pred;
                    out_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Ready is masked by reset so no beat is taken while the loader is held.
    assign in_ready  = (state_q == LOAD) && !rst;
    assign tnn_rst   = (state_q != RUN);
    assign busy      = (state_q != LOAD);
    assign features  = features_q;
    assign out_valid = out_valid_q;
    assign out_pred  = out_pred_q;
    assign dbg_state = state_q;

endmodule

// File: doc/tnn_feature_loader.md
Name: tnn_feature_loader

Overview:
- Upstream front-end for the sequential ternary classifier (pendigits, 16 features x 4 bits, 10 classes).
- Accepts features serially over a valid/ready stream and packs them into the flat feature vector.
- Holds the vector stable, restarts the classifier, waits a fixed compute latency, then captures the prediction and hands it downstream over a valid/ready result port.
- One inference in flight at a time.

Parameters:
- FEAT_CNT, 16, features per sample.
- FEAT_BITS, 4, bits per feature.
- CLASS_CNT, 10, classes; sets prediction width $clog2(CLASS_CNT).
- TNN_LATENCY, 64, cycles from classifier restart release to a valid prediction; must be >= classifier latency and >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  feature beat valid.
- in_ready  output  1  loader accepts a feature beat.
- in_feat  input  FEAT_BITS  one feature value.
- features  output  FEAT_CNT*FEAT_BITS  packed vector to the classifier `features` input.
- tnn_rst  output  1  synchronous restart to the classifier rst.
- tnn_pred  input  $clog2(CLASS_CNT)  classifier prediction.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_pred  output  $clog2(CLASS_CNT)  captured prediction.
- busy  output  1  high in every state except LOAD.

Behaviour:
- Reset (async assert, sync release): state=LOAD, beat counter=0, features=0, tnn_rst=1, out_valid=0, out_pred=0, cycle counter=0.
- Reset mid-operation aborts any partial load, run, or pending result. No result from an aborted inference is ever emitted.
- LOAD:
  - in_ready=1. tnn_rst=1, so the classifier is held idle.
  - A beat transfers on in_valid&in_ready.
  - Beat k (k=0..FEAT_CNT-1) is written to features[k*FEAT_BITS +: FEAT_BITS]. Feature 0 is in the LSBs.
  - On the transfer of beat FEAT_CNT-1: counter wraps to 0 and next state=START.
- START:
  - One cycle. in_ready=0, tnn_rst=1. features is stable from this cycle onward.
  - Next state=RUN with cycle counter=0.
- RUN:
  - tnn_rst=0, in_ready=0. Counter increments each cycle.
  - When counter==TNN_LATENCY-1: capture tnn_pred into out_pred, set out_valid=1, go to RESULT.
  - The result is therefore registered exactly TNN_LATENCY cycles after the first cycle with tnn_rst=0.
- RESULT:
  - out_valid=1, out_pred held constant, tnn_rst=1, features held.
  - in_ready=0. Incoming beats are backpressured, not dropped.
  - On out_valid&out_ready: out_valid=0 next cycle, state=LOAD.
  - The first beat of the next sample can be accepted on the cycle after the handshake; there is no same-cycle overlap.
- features changes only during LOAD, one field per accepted beat.
- out_pred changes only at capture and reset.
- Counter widths: beat counter $clog2(FEAT_CNT); cycle counter $clog2(TNN_LATENCY+1). Neither counter may overflow.
- Throughput: FEAT_CNT + 1 + TNN_LATENCY + 1 cycles minimum per sample when in_valid and out_ready are held high.

Decomposition:
- Shared package holds:
  - state enum {LOAD, START, RUN, RESULT};
  - pendigits constants FEAT_CNT=16, FEAT_BITS=4, CLASS_CNT=10;
  - derived widths PRED_W and FEAT_VEC_W.
- No sub-module: a single FSM with two counters.
- A top-level wrapper (separate) instantiates this loader plus the pendigits classifier.

Test Plan:
- Reset values: assert rst mid-clock -> immediately features=0, tnn_rst=1, out_valid=0, in_ready=0. After release, in_ready=1 and busy=0.
- Packing and ordering: send beats 0x0..0xF with in_valid held -> features=64'hFEDCBA9876543210. START lasts exactly 1 cycle after beat 15. busy=1, in_ready=0.
- Latency: TNN_LATENCY=64 with a stub driving tnn_pred=7 -> out_valid rises exactly 64 cycles after tnn_rst falls, out_pred=7, tnn_rst=1 again.
- Backpressure: out_ready=0 for 20 cycles while in_valid=1 with 0x3 -> out_pred stays 7, no beats accepted, features unchanged. out_ready=1 -> one handshake, and the next cycle accepts beat 0.
- Bubbles: in_valid toggled 1,0,0,1,... over 16 beats -> only valid cycles counted, features identical to the gap-free case.
- Reset mid-RUN: assert rst at cycle 30 of RUN, then load a new sample with a stub prediction of 2 -> exactly one result emitted, out_pred=2. No stale result appears.
